// File: rtl/io_display_ctrl.sv
// Seven-segment display controller: hex, dash or sequential shift-add-3 decimal
// conversion of a requested value, loaded into an active-low segment register.
module io_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 32,
  parameter int SW_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       num,
  input  logic                    out_req,
  input  logic                    in_req,
  input  logic                    hex_mode,
  input  logic                    signed_mode,
  input  logic                    blank_lz,
  input  logic [SW_W-1:0]         SW,
  output logic [DATA_W-1:0]       user_input,
  output logic                    req_ready,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] hex_seg
);

  // Smallest number of BCD digits that can hold 2^w - 1.
  function automatic int bcd_digits_for(input int w);
    logic [63:0] max_val;
    logic [63:0] pow;
    int          d;
    max_val = (64'd1 << w) - 64'd1;
    pow     = 64'd10;
    d       = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow <= max_val) begin
        pow = pow * 64'd10;
        d++;
      end
    end
    return d;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  localparam int BCD_DIGITS = bcd_digits_for(DATA_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_W-1:0]       shift_reg;
  logic [BCD_W-1:0]        bcd_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    dash_reg;
  logic                    hex_reg;
  logic                    neg_reg;
  logic                    blank_reg;
  logic [7*NUM_DIGITS-1:0] hex_seg_reg;

  logic                    accept;
  logic                    src_neg;
  logic [DATA_W-1:0]       src;
  logic [DATA_W-1:0]       magnitude;
  logic [BCD_W-2:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_shift;
  logic [3:0]              digit_val [NUM_DIGITS];
  logic                    overflow;
  int                      msd;
  int                      minus_pos;
  logic [7*NUM_DIGITS-1:0] pattern;

  assign user_input = DATA_W'(SW);
  assign hex_seg    = hex_seg_reg;

  assign accept    = (state_reg == IDLE) && (out_req ^ in_req);
  assign src       = out_req ? num : user_input;
  assign src_neg   = out_req && signed_mode && !hex_mode && num[DATA_W-1];
  assign magnitude = src_neg ? (~src) + DATA_W'(1) : src;

  // The top BCD digit never reaches 5 before a shift because the register is
  // sized exactly for 2^DATA_W-1, so it is passed through unadjusted.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS - 1; gi++) begin : g_dabble
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate
  assign bcd_adj[BCD_W-2:BCD_W-4] = bcd_reg[BCD_W-2:BCD_W-4];
  assign bcd_shift = {bcd_adj, shift_reg[DATA_W-1]};

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] hex_nib;
      logic [3:0] bcd_nib;
      if (4*gi + 4 <= DATA_W) begin : g_full
        assign hex_nib = shift_reg[4*gi +: 4];
      end else if (4*gi < DATA_W) begin : g_part
        assign hex_nib = 4'(shift_reg[DATA_W-1:4*gi]);
      end else begin : g_zero
        assign hex_nib = 4'd0;
      end
      if (gi < BCD_DIGITS) begin : g_bcd
        assign bcd_nib = bcd_reg[4*gi +: 4];
      end else begin : g_nobcd
        assign bcd_nib = 4'd0;
      end
      assign digit_val[gi] = hex_reg ? hex_nib : bcd_nib;
    end
  endgenerate

  // A negative result needs one digit for the minus sign, so its limit is one lower.
  always_comb begin
    overflow = 1'b0;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd_reg[4*k +: 4] != 4'd0 && k >= (neg_reg ? NUM_DIGITS - 1 : NUM_DIGITS))
        overflow = 1'b1;
    end
    if (hex_reg)
      overflow = 1'b0;
    msd = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_val[k] != 4'd0)
        msd = k;
    end
    minus_pos = blank_reg ? msd + 1 : NUM_DIGITS - 1;
  end

  always_comb begin
    pattern = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dash_reg)
        pattern[7*k +: 7] = SEG_DASH;
      else if (overflow)
        pattern[7*k +: 7] = SEG_ERR;
      else if (neg_reg && k == minus_pos)
        pattern[7*k +: 7] = SEG_DASH;
      else if (blank_reg && k > msd)
        pattern[7*k +: 7] = SEG_BLANK;
      else
        pattern[7*k +: 7] = glyph(digit_val[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if ((in_req && user_input == '0) || hex_mode)
            state_next = LOAD;
          else
            state_next = CONV;
        end
      end
      CONV: begin
        if (cnt_reg == CNT_W'(DATA_W - 1))
          state_next = LOAD;
      end
      LOAD: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg   <= '0;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      dash_reg    <= 1'b0;
      hex_reg     <= 1'b0;
      neg_reg     <= 1'b0;
      blank_reg   <= 1'b0;
      hex_seg_reg <= '1;
    end else begin
      if (accept) begin
        shift_reg <= magnitude;
        bcd_reg   <= '0;
        cnt_reg   <= '0;
        dash_reg  <= in_req && (user_input == '0);
        hex_reg   <= hex_mode;
        neg_reg   <= src_neg;
        blank_reg <= blank_lz;
      end
      if (state_reg == CONV) begin
        bcd_reg   <= bcd_shift;
        shift_reg <= shift_reg << 1;
        cnt_reg   <= cnt_reg + CNT_W'(1);
      end
      if (state_reg == LOAD)
        hex_seg_reg <= pattern;
    end
  end

endmodule

// File: tb/tb_io_display_ctrl.sv
// Scoreboard bench for io_display_ctrl: an arithmetic reference model predicts
// each display pattern and its latency; results are checked on LOAD completion.
module tb_io_display_ctrl;
  localparam int ND  = 8;
  localparam int DW  = 32;
  localparam int SWW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [DW-1:0]   num = '0;
  logic            out_req = 1'b0;
  logic            in_req = 1'b0;
  logic            hex_mode = 1'b0;
  logic            signed_mode = 1'b0;
  logic            blank_lz = 1'b0;
  logic [SWW-1:0]  SW = '0;
  logic [DW-1:0]   user_input;
  logic            req_ready;
  logic            done;
  logic [7*ND-1:0] hex_seg;

  io_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .SW_W(SWW)) dut (
    .clk(clk), .reset(reset), .num(num), .out_req(out_req), .in_req(in_req),
    .hex_mode(hex_mode), .signed_mode(signed_mode), .blank_lz(blank_lz), .SW(SW),
    .user_input(user_input), .req_ready(req_ready), .done(done), .hex_seg(hex_seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7*ND-1:0] seg;
    int              lat;
    int              acc;
  } exp_t;

  exp_t            sb_q[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc_cnt = 0;
  logic [7*ND-1:0] prev_seg = '1;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [7*ND-1:0] model(input logic [31:0] src, input bit from_in,
                                            input bit hx, input bit sg, input bit bl);
    logic [3:0]       d [ND];
    logic [7*ND-1:0]  r;
    bit               neg;
    longint unsigned  mag;
    longint unsigned  p;
    int               msd;
    if (from_in && src == 32'd0) return {ND{7'b0111111}};
    neg = !hx && sg && !from_in && src[31];
    mag = neg ? (64'h1_0000_0000 - 64'(src)) : 64'(src);
    if (!hx && mag >= (neg ? 64'd10000000 : 64'd100000000)) return {ND{7'b0000110}};
    p = 1;
    msd = 0;
    for (int i = 0; i < ND; i++) begin
      d[i] = hx ? src[4*i +: 4] : 4'((mag / p) % 64'd10);
      p = p * 10;
      if (d[i] != 4'd0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      r[7*i +: 7] = (bl && i > msd) ? 7'b1111111 : glyph_of(d[i]);
      if (neg && i == (bl ? msd + 1 : ND - 1)) r[7*i +: 7] = 7'b0111111;
    end
    return r;
  endfunction

  task automatic drive(input bit o, input bit i, input logic [31:0] n, input logic [3:0] sw,
                       input bit hx, input bit sg, input bit bl, input bit track);
    exp_t e;
    @(negedge clk);
    num = n; SW = sw; hex_mode = hx; signed_mode = sg; blank_lz = bl;
    out_req = o; in_req = i;
    @(posedge clk);
    #1;
    out_req = 1'b0; in_req = 1'b0;
    if (track && (o ^ i)) begin
      e.seg = model(o ? n : 32'(sw), i, hx, sg, bl);
      e.lat = ((i && sw == 4'd0) || hx) ? 1 : 33;
      e.acc = cyc_cnt;
      sb_q.push_back(e);
    end
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   guard;
    check({tag, "_sb"}, 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    if (e.lat > 1) check({tag, "_busy"}, 64'(req_ready), 64'd0);
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_held"}, 64'(hex_seg), 64'(prev_seg));
    @(posedge clk);
    #1;
    check({tag, "_lat"}, 64'(cyc_cnt - e.acc), 64'(e.lat));
    check({tag, "_seg"}, 64'(hex_seg), 64'(e.seg));
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    prev_seg = e.seg;
  endtask

  task automatic do_req(input string tag, input bit o, input bit i, input logic [31:0] n,
                        input logic [3:0] sw, input bit hx, input bit sg, input bit bl);
    int dcount;
    drive(o, i, n, sw, hx, sg, bl, 1'b1);
    if (o ^ i) begin
      collect(tag);
    end else begin
      dcount = 0;
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
      repeat (4) begin
        @(negedge clk);
        if (done) dcount++;
      end
      check({tag, "_nodone"}, 64'(dcount), 64'd0);
      check({tag, "_held"}, 64'(hex_seg), 64'(prev_seg));
    end
  endtask

  initial begin
    int dcount;
    logic [31:0] rn;
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dcount;
    logic [31:0] rn;
    repeat (2) @(posedge clk);
    #1;
    check("rst_seg", 64'(hex_seg), {8'd0, {ND{7'b1111111}}});
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    do_req("dec1234", 1, 0, 32'd1234, 4'd0, 0, 0, 1);
    do_req("neg1", 1, 0, 32'hFFFF_FFFF, 4'd0, 0, 1, 1);
    do_req("hexdead", 1, 0, 32'hDEAD_BEEF, 4'd0, 1, 0, 0);
    do_req("ovf_u", 1, 0, 32'd100000000, 4'd0, 0, 0, 0);
    do_req("max_u", 1, 0, 32'd99999999, 4'd0, 0, 0, 1);
    do_req("in_dash", 0, 1, 32'd0, 4'd0, 0, 0, 1);
    do_req("in_10", 0, 1, 32'd77, 4'b1010, 0, 0, 1);
    check("user_input", 64'(user_input), 64'd10);
    do_req("in_hexA", 0, 1, 32'd0, 4'b1010, 1, 0, 0);
    do_req("neg5_nob", 1, 0, 32'hFFFF_FFFB, 4'd0, 0, 1, 0);
    do_req("neg_max", 1, 0, 32'(-9999999), 4'd0, 0, 1, 1);
    do_req("neg_ovf", 1, 0, 32'(-10000000), 4'd0, 0, 1, 1);
    do_req("min_int", 1, 0, 32'h8000_0000, 4'd0, 0, 1, 0);
    do_req("uns_big", 1, 0, 32'hFFFF_FFFF, 4'd0, 0, 0, 1);
    do_req("zero_blz", 1, 0, 32'd0, 4'd0, 0, 0, 1);
    do_req("hex_blz", 1, 0, 32'h0000_00A0, 4'd0, 1, 0, 1);
    do_req("both_req", 1, 1, 32'd5, 4'd3, 1, 0, 0);
    do_req("no_req", 0, 0, 32'd5, 4'd3, 1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      rn = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 99999)) : $urandom;
      do_req($sformatf("rnd%0d", k), 1, 0, rn, 4'd0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Request during conversion must be dropped, not queued.
    drive(1, 0, 32'd4321, 4'd0, 0, 0, 1, 1'b1);
    repeat (4) @(negedge clk);
    num = 32'h1111_1111; hex_mode = 1'b1; out_req = 1'b1;
    @(negedge clk);
    out_req = 1'b0; hex_mode = 1'b0;
    collect("ign_conv");
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ign_noqueue", 64'(dcount), 64'd0);

    // Asynchronous reset part way through a conversion.
    drive(1, 0, 32'd87654321, 4'd0, 0, 0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_seg", 64'(hex_seg), {8'd0, {ND{7'b1111111}}});
    check("arst_ready", 64'(req_ready), 64'd1);
    check("arst_done", 64'(done), 64'd0);
    prev_seg = '1;
    dcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcount++;
    end
    reset = 1'b1;
    repeat (35) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("arst_nodone", 64'(dcount), 64'd0);
    do_req("post_rst", 1, 0, 32'h0000_C0DE, 4'd0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_display_ctrl.md
IO_DISPLAY_CTRL -- requirements
Module: io_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of 7-segment digits driven (2..8).
REQ-002 Parameter DATA_W, default 32: width of num (8..32).
REQ-003 Parameter SW_W, default 4: width of switch input (1..DATA_W).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately, independent of clk.
REQ-006 num  input  DATA_W  value to display on an output request.
REQ-007 out_req  input  1  output request; accepted only when req_ready is high.
REQ-008 in_req  input  1  input request; accepted only when req_ready is high.
REQ-009 hex_mode  input  1  1 = hexadecimal display, 0 = decimal; sampled at acceptance.
REQ-010 signed_mode  input  1  1 = decimal value is two's complement; sampled at acceptance, ignored when hex_mode=1.
REQ-011 blank_lz  input  1  1 = blank leading zeros; sampled at acceptance.
REQ-012 SW  input  SW_W  user switches.
REQ-013 user_input  output  DATA_W  SW zero-extended, combinational.
REQ-014 req_ready  output  1  high only in IDLE.
REQ-015 done  output  1  one-cycle pulse when a new display pattern is loaded.
REQ-016 hex_seg  output  7*NUM_DIGITS  active-low segments, digit i at bits [7i+6:7i], digit 0 least significant.

Function
REQ-017 States IDLE, CONV, LOAD; reset enters IDLE.
REQ-018 Accept on a rising edge in IDLE with exactly one of out_req/in_req high; source = num (out_req) or user_input (in_req); both high or both low -> no acceptance, display held.
REQ-019 Requests in CONV or LOAD are ignored, not queued.
REQ-020 in_req with user_input==0 -> IDLE to LOAD directly, all digits 0111111 (dash).
REQ-021 hex_mode=1 -> IDLE to LOAD; digit i = nibble i of source, zero above DATA_W.
REQ-022 hex_mode=0 -> CONV: sequential shift-add-3 binary-to-BCD, one source bit per cycle MSB first, exactly DATA_W cycles, then LOAD; internal BCD register sized for 2^DATA_W-1.
REQ-023 signed_mode=1 with source MSB set (out_req only): convert two's-complement magnitude; minus (0111111) drawn in digit immediately above most significant nonblank digit (blank_lz=1) or in digit NUM_DIGITS-1 (blank_lz=0).
REQ-024 Overflow: unsigned magnitude >= 10^NUM_DIGITS, or negative magnitude >= 10^(NUM_DIGITS-1) -> all digits 0000110 (E).
REQ-025 blank_lz=1: zero digits above the most significant nonzero digit show 1111111; value 0 shows single 0 in digit 0.
REQ-026 LOAD: hex_seg updated, done=1 for that cycle, next state IDLE.
REQ-027 Latency accept-to-hex_seg: 1 cycle hex/dash path, DATA_W+1 cycles decimal path.
REQ-028 Glyphs 0-F: 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000,0001000,0000011,1000110,0100001,0000110,0001110.
REQ-029 hex_seg changes only in LOAD or reset.

Reset
REQ-030 reset low: hex_seg all ones, done=0, req_ready=1 (IDLE), BCD/shift registers cleared, including mid-CONV abort with no done pulse.
REQ-031 First acceptance possible on first rising edge after reset deasserts.

Verification (NUM_DIGITS=8, DATA_W=32, SW_W=4)
REQ-032 out_req, num=1234, decimal, blank_lz=1 -> after 33 cycles digits0-3 = 0011001,0110000,0100100,1111001, digits4-7 = 1111111, done one cycle.
REQ-033 out_req, num=32'hFFFFFFFF, signed_mode=1, blank_lz=1 -> digit0=1111001, digit1=0111111, digits2-7 blank.
REQ-034 out_req, num=32'hDEADBEEF, hex_mode=1 -> after 1 cycle digits0-7 = F,E,E,B,D,A,E,D glyphs.
REQ-035 out_req, num=100000000, decimal unsigned -> all digits 0000110.
REQ-036 in_req, SW=0 -> all digits 0111111 after 1 cycle; in_req, SW=4'b1010, decimal, blank_lz=1 -> digit0=1000000, digit1=1111001, rest blank; user_input=10.
REQ-037 reset low at cycle 10 of a decimal conversion -> hex_seg all ones immediately, no done, req_ready=1; out_req during CONV ignored.
